// File: rtl/booth_mac_accum.sv
// booth_mac_accum
// Accumulates signed products from the sequential Booth multiplier into a
// saturating sum and emits one dot-product result per vector on a
// valid/ready output. A vector closes after N_TERMS accepted products or on
// an accepted product flagged with last_in, whichever comes first.
module booth_mac_accum #(
  parameter int PW      = 16,
  parameter int AW      = 24,
  parameter int N_TERMS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [PW-1:0]             prod_in,
  input  logic                      prod_valid,
  input  logic                      last_in,
  output logic                      prod_ready,
  output logic [AW-1:0]             acc_out,
  output logic                      acc_valid,
  input  logic                      acc_ready,
  output logic                      ovf,
  output logic [$clog2(N_TERMS):0]  term_cnt
);

  localparam int CW = $clog2(N_TERMS) + 1;
  localparam logic [CW-1:0] LAST_TERM = CW'(N_TERMS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] sum;

  logic [AW:0]   wide_sum;
  logic [AW-1:0] sat_sum;
  logic          sat_hit;
  logic          accept;
  logic          close;

  // One guard bit above the accumulator catches overflow in either direction.
  assign wide_sum = {sum[AW-1], sum} + {{(AW + 1 - PW){prod_in[PW-1]}}, prod_in};

  // Clamp to the most positive / most negative AW-bit value when the guard
  // bit disagrees with the accumulator sign bit.
  always_comb begin
    sat_hit = wide_sum[AW] ^ wide_sum[AW-1];
    sat_sum = wide_sum[AW-1:0];
    if (sat_hit) begin
      if (wide_sum[AW]) begin
        sat_sum = {1'b1, {(AW - 1){1'b0}}};
      end else begin
        sat_sum = {1'b0, {(AW - 1){1'b1}}};
      end
    end
  end

  assign accept = prod_valid & prod_ready;
  assign close  = accept & ((term_cnt == LAST_TERM) | last_in);

  // Accumulate / hold state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      sum        <= '0;
      term_cnt   <= '0;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      ovf        <= 1'b0;
      prod_ready <= 1'b1;
    end else if (clear) begin
      // Abort wins over everything: partial sum and any held result vanish.
      state      <= ACCUM;
      sum        <= '0;
      term_cnt   <= '0;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      ovf        <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            sum      <= sat_sum;
            term_cnt <= term_cnt + 1'b1;
            if (sat_hit) begin
              ovf <= 1'b1;
            end
            if (close) begin
              acc_out    <= sat_sum;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          // No bypass: the cycle that releases the result takes no product.
          // acc_out keeps the last result after the handshake.
          if (acc_ready) begin
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
            sum        <= '0;
            term_cnt   <= '0;
            ovf        <= 1'b0;
            state      <= ACCUM;
          end
        end
        default: begin
          state      <= ACCUM;
          prod_ready <= 1'b1;
          acc_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum: two instances (AW=24 and AW=18) share one
// stimulus stream; a cycle model predicts handshake/counter behaviour and a
// result queue holds the expected dot products until each is taken.
module tb_booth_mac_accum;

  localparam int PW = 16;
  localparam int NT = 8;
  localparam int AWA = 24;
  localparam int AWB = 18;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic [PW-1:0]     prod_in;
  logic              prod_valid;
  logic              last_in;
  logic              acc_ready;

  logic              prod_ready_a, prod_ready_b;
  logic [AWA-1:0]    acc_out_a;
  logic [AWB-1:0]    acc_out_b;
  logic              acc_valid_a, acc_valid_b;
  logic              ovf_a, ovf_b;
  logic [$clog2(NT):0] term_cnt_a, term_cnt_b;

  booth_mac_accum #(.PW(PW), .AW(AWA), .N_TERMS(NT)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_in(prod_in),
    .prod_valid(prod_valid), .last_in(last_in), .prod_ready(prod_ready_a),
    .acc_out(acc_out_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
    .ovf(ovf_a), .term_cnt(term_cnt_a)
  );

  booth_mac_accum #(.PW(PW), .AW(AWB), .N_TERMS(NT)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .prod_in(prod_in),
    .prod_valid(prod_valid), .last_in(last_in), .prod_ready(prod_ready_b),
    .acc_out(acc_out_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
    .ovf(ovf_b), .term_cnt(term_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    bit oa;
    int b;
    bit ob;
  } res_t;

  res_t sb[$];

  int tests = 0;
  int fails = 0;

  // Model state: what the DUTs should show after the most recent edge.
  int m_sum_a, m_sum_b, m_out_a, m_out_b, m_cnt;
  bit m_ovf_a, m_ovf_b, m_hold;

  function automatic int sat(input int s, input int aw, output bit hit);
    int hi, lo;
    hi = (1 << (aw - 1)) - 1;
    lo = -(1 << (aw - 1));
    hit = 1'b0;
    if (s > hi) begin
      hit = 1'b1;
      return hi;
    end
    if (s < lo) begin
      hit = 1'b1;
      return lo;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum_a = 0; m_sum_b = 0; m_out_a = 0; m_out_b = 0; m_cnt = 0;
    m_ovf_a = 0; m_ovf_b = 0; m_hold = 0;
    sb.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_a"}, acc_valid_a, m_hold);
    chk({tag, ".valid_b"}, acc_valid_b, m_hold);
    chk({tag, ".ready_a"}, prod_ready_a, !m_hold);
    chk({tag, ".ready_b"}, prod_ready_b, !m_hold);
    chk({tag, ".cnt_a"}, term_cnt_a, m_cnt);
    chk({tag, ".cnt_b"}, term_cnt_b, m_cnt);
    chk({tag, ".out_a"}, $signed(acc_out_a), m_out_a);
    chk({tag, ".out_b"}, $signed(acc_out_b), m_out_b);
    if (m_hold) begin
      chk({tag, ".ovf_a"}, ovf_a, m_ovf_a);
      chk({tag, ".ovf_b"}, ovf_b, m_ovf_b);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // across the next rising edge, then check at the following falling edge.
  task automatic step(input string tag, input bit pv, input int p, input bit last,
                      input bit ar, input bit clr);
    bit ha, hb;
    res_t r;
    prod_valid = pv;
    prod_in    = PW'(p);
    last_in    = last;
    acc_ready  = ar;
    clear      = clr;
    if (clr) begin
      model_reset();
    end else if (m_hold) begin
      if (ar) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $error("FAIL %s.sb_empty observed=0 expected=1", tag);
        end else begin
          r = sb.pop_front();
          chk({tag, ".res_a"}, $signed(acc_out_a), r.a);
          chk({tag, ".res_b"}, $signed(acc_out_b), r.b);
          chk({tag, ".rovf_a"}, ovf_a, r.oa);
          chk({tag, ".rovf_b"}, ovf_b, r.ob);
        end
        m_hold = 0; m_sum_a = 0; m_sum_b = 0; m_cnt = 0;
        m_ovf_a = 0; m_ovf_b = 0;
      end
    end else if (pv) begin
      m_sum_a = sat(m_sum_a + p, AWA, ha);
      m_sum_b = sat(m_sum_b + p, AWB, hb);
      m_ovf_a = m_ovf_a | ha;
      m_ovf_b = m_ovf_b | hb;
      m_cnt++;
      if (m_cnt == NT || last) begin
        m_out_a = m_sum_a;
        m_out_b = m_sum_b;
        m_hold  = 1;
        sb.push_back('{a: m_sum_a, oa: m_ovf_a, b: m_sum_b, ob: m_ovf_b});
      end
    end
    @(negedge clk);
    check_outputs(tag);
    $display("[TB] %s pv=%0d p=%0d last=%0d ar=%0d clr=%0d -> out_a=%0d out_b=%0d valid=%0d cnt=%0d",
             tag, pv, p, last, ar, clr, $signed(acc_out_a), $signed(acc_out_b),
             acc_valid_a, term_cnt_a);
  endtask

  task automatic async_reset(input string tag);
    prod_valid = 0; last_in = 0; acc_ready = 0; clear = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".now"});
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs({tag, ".rel"});
  endtask

  initial begin
    rst_n = 1'b0; clear = 0; prod_in = '0; prod_valid = 0; last_in = 0; acc_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs("reset");

    // 8 x 10 with consumer always ready
    for (int i = 0; i < NT; i++) step("dot80", 1, 10, 0, 1, 0);
    step("dot80_hs", 0, 0, 0, 1, 0);
    step("idle", 0, 0, 0, 1, 0);

    // positive then negative saturation (AW=18 saturates, AW=24 does not)
    for (int i = 0; i < NT; i++) step("satp", 1, 32767, 0, 1, 0);
    step("satp_hs", 0, 0, 0, 1, 0);
    for (int i = 0; i < NT; i++) step("satn", 1, -32768, 0, 1, 0);
    step("satn_hs", 0, 0, 0, 1, 0);

    // early close with last_in; lone last_in without valid is ignored
    step("early", 1, 7, 0, 1, 0);
    step("lastnv", 0, 0, 1, 1, 0);
    step("early", 1, -3, 0, 1, 0);
    step("early", 1, 2, 1, 1, 0);
    step("early_hs", 0, 0, 0, 1, 0);

    // backpressure: result held, products stalled, none lost
    for (int i = 0; i < NT; i++) step("bp_fill", 1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("bp_hold", 1, 9, 0, 0, 0);
    step("bp_hs", 1, 9, 0, 1, 0);
    step("bp_resume", 1, 9, 0, 1, 0);
    for (int i = 0; i < NT - 1; i++) step("bp_rest", 1, 1, 0, 1, 0);
    step("bp_hs2", 0, 0, 0, 1, 0);

    // clear discards partial sum and the product offered with it
    for (int i = 0; i < 4; i++) step("clr_part", 1, 100, 0, 1, 0);
    step("clr", 1, 100, 0, 1, 1);
    for (int i = 0; i < NT; i++) step("clr_after", 1, 1, 0, 1, 0);
    step("clr_hs", 0, 0, 0, 1, 0);

    // clear while a result is held drops it and zeroes acc_out
    step("clrh_v", 1, 42, 1, 0, 0);
    step("clrh_wait", 0, 0, 0, 0, 0);
    step("clrh", 0, 0, 0, 1, 1);

    // async reset mid-vector and while holding
    for (int i = 0; i < 3; i++) step("rst_mid", 1, 11, 0, 1, 0);
    async_reset("rst_mid");
    step("rst_hold_v", 1, -5, 1, 0, 0);
    async_reset("rst_hold");

    // randomised traffic
    for (int i = 0; i < 120; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 65535) - 32768,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 40) == 0));
    end
    step("drain", 0, 0, 0, 1, 0);
    step("drain", 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
